text_console_writer: RTL and testbench
======================================

TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 SHALL have parameter MAX_X, default 80, meaning text columns per row.
REQ-002 SHALL have parameter MAX_Y, default 30, meaning text rows per screen.
REQ-003 SHALL have parameter BLANK, default 7'h20, meaning the fill code written when clearing.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  character byte offered.
REQ-007 SHALL have port in_data  input  7  ASCII code offered.
REQ-008 SHALL have port in_ready  output  1  block can accept a character this cycle.
REQ-009 SHALL have port wr_en  output  1  tile RAM write strobe.
REQ-010 SHALL have port wr_addr  output  12  tile RAM address {row[4:0], col[6:0]}.
REQ-011 SHALL have port wr_data  output  7  tile RAM write data.
REQ-012 SHALL have port cur_x  output  7  cursor column, for the display cursor overlay.
REQ-013 SHALL have port cur_y  output  5  cursor row.
REQ-014 SHALL have port busy  output  1  a clear operation is in progress.

Function
REQ-015 SHALL implement FSM states IDLE, CLR_LINE and CLR_SCREEN; in_ready = (state==IDLE) combinationally, busy = ~in_ready.
REQ-016 SHALL accept a character on a rising edge where in_valid && in_ready; in_data is not sampled otherwise.
REQ-017 SHALL register wr_en, wr_addr and wr_data; wr_en is low in every cycle with no write.
REQ-018 Printable code (0x20..0x7E) accepted at edge E SHALL give wr_en=1, wr_addr={old cur_y, old cur_x}, wr_data=in_data in the cycle after E, with the cursor advanced at the same edge.
REQ-019 Cursor advance SHALL be cur_x+1; from cur_x=MAX_X-1 it SHALL set cur_x=0 and cur_y=cur_y+1, with cur_y=MAX_Y-1 wrapping to 0.
REQ-020 LF (0x0A) SHALL set cur_x=0 and advance cur_y with the same wrap, and SHALL issue no character write.
REQ-021 CR (0x0D) SHALL set cur_x=0 and leave cur_y unchanged, with no write.
REQ-022 BS (0x08) at cur_x>0 SHALL set cur_x-1 and write BLANK at the new position.
REQ-023 BS at cur_x=0 and cur_y>0 SHALL move the cursor to (MAX_X-1, cur_y-1) and write BLANK there.
REQ-024 BS at (0,0) SHALL be consumed with no write and no cursor change.
REQ-025 FF (0x0C) SHALL set the cursor to (0,0) and enter CLR_SCREEN.
REQ-026 All other codes (0x00..0x1F not listed, and 0x7F) SHALL be consumed with no write and no cursor change.
REQ-027 Any acceptance that changes cur_y (wrap or LF) SHALL enter CLR_LINE at the same edge with clear column 0 and clear row equal to the new cur_y.
REQ-028 In CLR_LINE, each edge SHALL produce wr_en=1, wr_addr={clr_row, clr_col}, wr_data=BLANK and increment clr_col, giving exactly MAX_X consecutive writes (cols 0..MAX_X-1).
REQ-029 CLR_LINE SHALL return to IDLE on the edge that issues col MAX_X-1.
REQ-030 In CLR_SCREEN, writes SHALL run row-major with one write per edge over rows 0..MAX_Y-1 and cols 0..MAX_X-1, giving MAX_X*MAX_Y writes.
REQ-031 CLR_SCREEN SHALL return to IDLE after writing ({MAX_Y-1, MAX_X-1}); addresses with col >= MAX_X are never written.
REQ-032 SHALL not change the cursor during CLR_LINE or CLR_SCREEN.
REQ-033 The character write of REQ-018 SHALL occur in the cycle before the first CLR_LINE write.

Reset
REQ-034 While reset is high: state=CLR_SCREEN, cur_x=0, cur_y=0, clear counters=0, wr_en=0, wr_addr=0, wr_data=0.
REQ-035 After reset deasserts, a full screen clear (REQ-030/031) SHALL run before in_ready first rises.
REQ-036 Reset asserted mid-clear or mid-write SHALL abort the operation immediately and restart per REQ-034/035.

Verification
REQ-037 Reset release -> in_ready=0 for exactly 2400 cycles, 2400 writes of 7'h20 covering rows 0..29 and cols 0..79 only, then in_ready=1 with cursor (0,0).
REQ-038 Send 'A' (0x41) then 'B' at (0,0) -> writes (addr 0x000, 0x41) then (0x001, 0x42); cursor ends at (2,0); no other writes.
REQ-039 Cursor at (79,3), send 'Z' -> write {3,79}=0x5A, cursor (0,4), then 80 BLANK writes to row 4 cols 0..79, in_ready low for those 80 cycles.
REQ-040 Cursor at (5,29), send LF -> cursor (0,0), no character write, row 0 cleared (80 writes).
REQ-041 BS at (0,7) -> cursor (79,6) with BLANK written at {6,79}; BS at (0,0) -> no write, cursor unchanged.
REQ-042 Hold in_valid high with FF, then 'x' -> FF accepted, 2400-cycle clear with in_ready=0, 'x' accepted next cycle and written at 0x000.

Source files
------------

// File: rtl/text_console_writer.sv
// Text console writer: turns a stream of ASCII codes into tile RAM writes.
// Keeps a cursor, interprets LF/CR/BS/FF, and blanks the new line on every
// row change and the whole screen on FF or after reset.
module text_console_writer #(
    parameter int unsigned MAX_X = 80,
    parameter int unsigned MAX_Y = 30,
    parameter logic [6:0]  BLANK = 7'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [6:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [6:0]  wr_data,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic        busy
);

    localparam logic [6:0] XLast = 7'(MAX_X - 1);
    localparam logic [4:0] YLast = 5'(MAX_Y - 1);

    localparam logic [6:0] ChBs = 7'h08;
    localparam logic [6:0] ChLf = 7'h0A;
    localparam logic [6:0] ChFf = 7'h0C;
    localparam logic [6:0] ChCr = 7'h0D;

    typedef enum logic [1:0] {StIdle, StClrLine, StClrScreen} state_e;

    state_e      state_q, state_d;
    logic [6:0]  cur_x_q, cur_x_d;
    logic [4:0]  cur_y_q, cur_y_d;
    logic [6:0]  clr_col_q, clr_col_d;
    logic [4:0]  clr_row_q, clr_row_d;
    logic        wr_en_q, wr_en_d;
    logic [11:0] wr_addr_q, wr_addr_d;
    logic [6:0]  wr_data_q, wr_data_d;

    logic        printable;
    logic [4:0]  y_next;

    assign printable = (in_data >= 7'h20) && (in_data <= 7'h7E);
    // Row below the cursor, wrapping from the last row back to the top.
    assign y_next    = (cur_y_q == YLast) ? 5'd0 : cur_y_q + 5'd1;

    // State, cursor, clear counters and registered write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StClrScreen;
            cur_x_q   <= 7'd0;
            cur_y_q   <= 5'd0;
            clr_col_q <= 7'd0;
            clr_row_q <= 5'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 12'd0;
            wr_data_q <= 7'd0;
        end else begin
            state_q   <= state_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            clr_col_q <= clr_col_d;
            clr_row_q <= clr_row_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next state: character decode in idle, counter stepping while clearing.
    always_comb begin
        state_d   = state_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        clr_col_d = clr_col_q;
        clr_row_d = clr_row_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (printable) begin
                        if (cur_x_q == XLast) begin
                            cur_x_d   = 7'd0;
                            cur_y_d   = y_next;
                            clr_col_d = 7'd0;
                            clr_row_d = y_next;
                            state_d   = StClrLine;
                        end else begin
                            cur_x_d = cur_x_q + 7'd1;
                        end
                    end else begin
                        unique case (in_data)
                            ChLf: begin
                                cur_x_d   = 7'd0;
                                cur_y_d   = y_next;
                                clr_col_d = 7'd0;
                                clr_row_d = y_next;
                                state_d   = StClrLine;
                            end
                            ChCr: cur_x_d = 7'd0;
                            ChBs: begin
                                if (cur_x_q != 7'd0) begin
                                    cur_x_d = cur_x_q - 7'd1;
                                end else if (cur_y_q != 5'd0) begin
                                    cur_x_d = XLast;
                                    cur_y_d = cur_y_q - 5'd1;
                                end
                            end
                            ChFf: begin
                                cur_x_d   = 7'd0;
                                cur_y_d   = 5'd0;
                                clr_col_d = 7'd0;
                                clr_row_d = 5'd0;
                                state_d   = StClrScreen;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StClrLine: begin
                if (clr_col_q == XLast) begin
                    clr_col_d = 7'd0;
                    state_d   = StIdle;
                end else begin
                    clr_col_d = clr_col_q + 7'd1;
                end
            end
            StClrScreen: begin
                if (clr_col_q == XLast) begin
                    clr_col_d = 7'd0;
                    if (clr_row_q == YLast) begin
                        clr_row_d = 5'd0;
                        state_d   = StIdle;
                    end else begin
                        clr_row_d = clr_row_q + 5'd1;
                    end
                end else begin
                    clr_col_d = clr_col_q + 7'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Write port next values; address and data hold when no write is issued.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (printable) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {cur_y_q, cur_x_q};
                        wr_data_d = in_data;
                    end else if (in_data == ChBs) begin
                        if (cur_x_q != 7'd0) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = {cur_y_q, cur_x_q - 7'd1};
                            wr_data_d = BLANK;
                        end else if (cur_y_q != 5'd0) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = {cur_y_q - 5'd1, XLast};
                            wr_data_d = BLANK;
                        end
                    end
                end
            end
            StClrLine, StClrScreen: begin
                wr_en_d   = 1'b1;
                wr_addr_d = {clr_row_q, clr_col_q};
                wr_data_d = BLANK;
            end
            default: ;
        endcase
    end

    assign in_ready = (state_q == StIdle);
    assign busy     = ~in_ready;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cur_x    = cur_x_q;
    assign cur_y    = cur_y_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: a screen-level reference model
// queues the expected tile writes; a negedge monitor pops and compares them.
module tb_text_console_writer;

    localparam int MAX_X = 80;
    localparam int MAX_Y = 30;
    localparam logic [6:0] BLANK = 7'h20;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [6:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [6:0]  wr_data;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;

    text_console_writer #(
        .MAX_X(MAX_X),
        .MAX_Y(MAX_Y),
        .BLANK(BLANK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .cur_x(cur_x),
        .cur_y(cur_y),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 0;
    logic [18:0] exp_q[$];
    int mx = 0;
    int my = 0;

    // ---------------- reference model ----------------
    task automatic push_wr(input int x, input int y, input logic [6:0] d);
        logic [4:0] yy;
        logic [6:0] xx;
        yy = 5'(y);
        xx = 7'(x);
        exp_q.push_back({yy, xx, d});
    endtask

    task automatic model_clear_row(input int r);
        for (int i = 0; i < MAX_X; i++) push_wr(i, r, BLANK);
    endtask

    task automatic model_clear_screen();
        for (int r = 0; r < MAX_Y; r++) model_clear_row(r);
    endtask

    // Applies one accepted code; returns how many cycles the block stays busy.
    task automatic model_apply(input logic [6:0] c, output int busy_n);
        busy_n = 0;
        if (c >= 7'h20 && c <= 7'h7E) begin
            push_wr(mx, my, c);
            mx = mx + 1;
            if (mx == MAX_X) begin
                mx = 0;
                my = (my + 1) % MAX_Y;
                model_clear_row(my);
                busy_n = MAX_X;
            end
        end else if (c == 7'h0A) begin
            mx = 0;
            my = (my + 1) % MAX_Y;
            model_clear_row(my);
            busy_n = MAX_X;
        end else if (c == 7'h0D) begin
            mx = 0;
        end else if (c == 7'h08) begin
            if (mx > 0) begin
                mx = mx - 1;
                push_wr(mx, my, BLANK);
            end else if (my > 0) begin
                my = my - 1;
                mx = MAX_X - 1;
                push_wr(mx, my, BLANK);
            end
        end else if (c == 7'h0C) begin
            mx = 0;
            my = 0;
            model_clear_screen();
            busy_n = MAX_X * MAX_Y;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [18:0] e;
        if (mon_en && !reset) begin
            n_cmp++;
            if (busy !== ~in_ready) begin
                n_bad++;
                $display("FAIL busy_vs_ready: busy=%b in_ready=%b", busy, in_ready);
            end
            if (wr_en === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write: addr=%h data=%h, none expected",
                             wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({wr_addr, wr_data} !== e) begin
                        n_bad++;
                        $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                                 wr_addr, wr_data, e[18:7], e[6:0]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_cursor(input string nm);
        n_cmp++;
        if (cur_x !== 7'(mx) || cur_y !== 5'(my)) begin
            n_bad++;
            $display("FAIL cursor_%s: got (%0d,%0d), expected (%0d,%0d)",
                     nm, cur_x, cur_y, mx, my);
        end
    endtask

    // Counts cycles with in_ready low, ending on the negedge where it is high.
    task automatic wait_idle(input int exp_n, input string nm);
        int n;
        n = 0;
        for (int g = 0; g < 5000; g++) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            n++;
        end
        n_cmp++;
        if (n != exp_n) begin
            n_bad++;
            $display("FAIL busy_len_%s: got %0d cycles, expected %0d", nm, n, exp_n);
        end
        check_cursor(nm);
    endtask

    task automatic send(input logic [6:0] c, input bit hold, input logic [6:0] next_c);
        int b;
        int guard;
        in_valid = 1'b1;
        in_data  = c;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready=%b, expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        model_apply(c, b);
        @(posedge clk);
        #1;
        if (hold) in_data = next_c;
        else in_valid = 1'b0;
        wait_idle(b, "after_char");
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wr_en !== 1'b0 || wr_addr !== 12'd0 || wr_data !== 7'd0 ||
            in_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_outputs: wr_en=%b addr=%h data=%h ready=%b busy=%b, expected 0 0 0 0 1",
                     wr_en, wr_addr, wr_data, in_ready, busy);
        end
        exp_q.delete();
        mx = 0;
        my = 0;
        check_cursor("reset");
        model_clear_screen();
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    function automatic logic [6:0] rand_print();
        return 7'($urandom_range(32, 126));
    endfunction

    function automatic logic [6:0] rand_code();
        int r;
        logic [6:0] c;
        r = $urandom_range(0, 99);
        if (r < 70) c = rand_print();
        else if (r < 78) c = 7'h0A;
        else if (r < 84) c = 7'h0D;
        else if (r < 93) c = 7'h08;
        else if (r < 95) c = 7'h0C;
        else begin
            c = 7'($urandom_range(0, 32));
            if (c == 7'd32) c = 7'h7F;
            if (c == 7'h08 || c == 7'h0A || c == 7'h0C || c == 7'h0D) c = 7'h01;
        end
        return c;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 7'h00;
        #2 reset = 1'b1;

        // Power-up clear.
        reset_pulse();
        wait_idle(MAX_X * MAX_Y, "powerup_clear");

        // Abort a clear part-way with reset; a full clear must restart.
        send(7'h0C, 1'b0, 7'h00);
        send(7'h41, 1'b0, 7'h00);
        reset_pulse();
        repeat (700) @(negedge clk);
        reset_pulse();
        wait_idle(MAX_X * MAX_Y, "restart_clear");

        // Two characters from home.
        send(7'h41, 1'b0, 7'h00);
        send(7'h42, 1'b0, 7'h00);

        // Line wrap from (79,3).
        send(7'h0D, 1'b0, 7'h00);
        while (my != 3) send(7'h0A, 1'b0, 7'h00);
        while (mx != MAX_X - 1) send(rand_print(), 1'b0, 7'h00);
        send(7'h5A, 1'b0, 7'h00);

        // LF from the last row wraps to row 0.
        while (my != MAX_Y - 1) send(7'h0A, 1'b0, 7'h00);
        while (mx != 5) send(rand_print(), 1'b0, 7'h00);
        send(7'h0A, 1'b0, 7'h00);

        // Backspace across a row boundary, then at home.
        while (my != 7) send(7'h0A, 1'b0, 7'h00);
        send(7'h08, 1'b0, 7'h00);
        send(7'h0C, 1'b0, 7'h00);
        send(7'h08, 1'b0, 7'h00);

        // FF with in_valid held, next character queued behind the clear.
        send(7'h0C, 1'b1, 7'h78);
        send(7'h78, 1'b0, 7'h00);

        // Random traffic.
        for (int i = 0; i < 400; i++) send(rand_code(), 1'b0, 7'h00);

        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_writes: %0d outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
